// File: rtl/echo_range_calc_pkg.sv
// Shared types and board defaults for the echo range conversion path.
package echo_range_calc_pkg;

    // Conversion controller states.
    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StUpd
    } state_e;

    // 50 MHz clock, 343 m/s, round trip: mm per cycle scaled by 2^16.
    localparam int unsigned DefMult  = 225;
    localparam int unsigned DefShift = 16;
    // Roughly 4 m of range at 50 MHz.
    localparam int unsigned DefMaxPw = 1200000;

endpackage

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one constant bit per cycle, LSB first.
// After start, runs for exactly K_W cycles; done is high during the last
// iteration and product holds the full result from the following cycle on.
module seq_shift_add_mult #(
    parameter int unsigned OP_W = 32,
    parameter int unsigned K_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [OP_W-1:0]       operand,
    input  logic [K_W-1:0]        constant,
    output logic [OP_W+K_W-1:0]   product,
    output logic                  done
);

    localparam int unsigned AccW = OP_W + K_W;
    localparam int unsigned CntW = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(K_W - 1);

    logic [OP_W-1:0] op_q, op_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;

    // Next-state: load on start, otherwise add the shifted operand per set bit.
    always_comb begin
        op_d  = op_q;
        k_d   = k_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            op_d  = operand;
            k_d   = constant;
            acc_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (k_q[cnt_q]) begin
                acc_d = acc_q + (AccW'(op_q) << cnt_q);
            end
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastBit) begin
                run_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= '0;
            k_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            k_q   <= k_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign product = acc_q;
    assign done    = run_q && (cnt_q == LastBit);

endmodule

// File: rtl/echo_range_calc.sv
// Converts echo pulse widths to millimetres, flags bad samples and keeps a
// power-of-two moving average of the good ones.
module echo_range_calc
    import echo_range_calc_pkg::*;
#(
    parameter int unsigned PW_W     = 32,
    parameter int unsigned MULT_W   = 16,
    parameter int unsigned MULT     = DefMult,
    parameter int unsigned SHIFT    = DefShift,
    parameter int unsigned DIST_W   = 16,
    parameter int unsigned MAX_PW   = DefMaxPw,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [PW_W-1:0]   pulse_width,
    input  logic              flush,
    output logic              busy,
    output logic              dist_valid,
    output logic [DIST_W-1:0] dist_mm,
    output logic              err_range,
    output logic              err_noecho,
    output logic              overrun,
    output logic [DIST_W-1:0] dist_avg,
    output logic              avg_valid
);

    localparam int unsigned AccW  = PW_W + MULT_W;
    localparam int unsigned Depth = 1 << AVG_LOG2;
    localparam int unsigned SumW  = DIST_W + AVG_LOG2;
    localparam int unsigned FillW = AVG_LOG2 + 1;
    localparam logic [PW_W-1:0] MaxPw = PW_W'(MAX_PW);

    state_e state_q, state_d;
    logic   rdy_q;
    logic   pend_range_q, pend_range_d, pend_noecho_q, pend_noecho_d;
    logic   dist_valid_q, dist_valid_d, overrun_q, overrun_d;
    logic   err_range_q, err_range_d, err_noecho_q, err_noecho_d;
    logic [DIST_W-1:0]   dist_mm_q, dist_mm_d;
    logic [DIST_W-1:0]   samples_q [Depth];
    logic [DIST_W-1:0]   samples_d [Depth];
    logic [SumW-1:0]     sum_q, sum_d;
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FillW-1:0]    fill_q, fill_d;

    logic              event_rise, pw_zero, pw_big, mult_start, mult_done;
    logic [AccW-1:0]   mult_product, prod_shift;
    logic [DIST_W-1:0] dist_sat;

    assign event_rise = rdy & ~rdy_q;
    assign pw_zero    = (pulse_width == '0);
    assign pw_big     = (pulse_width > MaxPw);
    assign prod_shift = mult_product >> SHIFT;
    assign dist_sat   = (|prod_shift[AccW-1:DIST_W]) ? '1 : prod_shift[DIST_W-1:0];

    seq_shift_add_mult #(
        .OP_W (PW_W),
        .K_W  (MULT_W)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .start    (mult_start),
        .operand  (pulse_width),
        .constant (MULT_W'(MULT)),
        .product  (mult_product),
        .done     (mult_done)
    );

    // Controller next-state, result registers and average buffer update.
    always_comb begin
        state_d       = state_q;
        pend_range_d  = pend_range_q;
        pend_noecho_d = pend_noecho_q;
        dist_valid_d  = 1'b0;
        overrun_d     = 1'b0;
        err_range_d   = err_range_q;
        err_noecho_d  = err_noecho_q;
        dist_mm_d     = dist_mm_q;
        samples_d     = samples_q;
        sum_d         = sum_q;
        wr_ptr_d      = wr_ptr_q;
        fill_d        = fill_q;
        mult_start    = 1'b0;

        if (event_rise && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (event_rise) begin
                    pend_noecho_d = pw_zero;
                    pend_range_d  = pw_big;
                    if (pw_zero || pw_big) begin
                        state_d = StUpd;
                    end else begin
                        mult_start = 1'b1;
                        state_d    = StMul;
                    end
                end
            end
            StMul: begin
                if (mult_done) begin
                    state_d = StUpd;
                end
            end
            StUpd: begin
                dist_valid_d = 1'b1;
                err_range_d  = pend_range_q;
                err_noecho_d = pend_noecho_q;
                state_d      = StIdle;
                if (pend_range_q || pend_noecho_q) begin
                    dist_mm_d = '1;
                end else begin
                    dist_mm_d = dist_sat;
                    // A coinciding flush drops this sample from the average only.
                    if (!flush) begin
                        samples_d[wr_ptr_q] = dist_sat;
                        sum_d    = sum_q - SumW'(samples_q[wr_ptr_q]) + SumW'(dist_sat);
                        wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
                        if (fill_q != FillW'(Depth)) begin
                            fill_d = fill_q + FillW'(1);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            samples_d = '{default: '0};
            sum_d     = '0;
            wr_ptr_d  = '0;
            fill_d    = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            rdy_q         <= 1'b0;
            pend_range_q  <= 1'b0;
            pend_noecho_q <= 1'b0;
            dist_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            err_range_q   <= 1'b0;
            err_noecho_q  <= 1'b0;
            dist_mm_q     <= '0;
            samples_q     <= '{default: '0};
            sum_q         <= '0;
            wr_ptr_q      <= '0;
            fill_q        <= '0;
        end else begin
            state_q       <= state_d;
            rdy_q         <= rdy;
            pend_range_q  <= pend_range_d;
            pend_noecho_q <= pend_noecho_d;
            dist_valid_q  <= dist_valid_d;
            overrun_q     <= overrun_d;
            err_range_q   <= err_range_d;
            err_noecho_q  <= err_noecho_d;
            dist_mm_q     <= dist_mm_d;
            samples_q     <= samples_d;
            sum_q         <= sum_d;
            wr_ptr_q      <= wr_ptr_d;
            fill_q        <= fill_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign dist_valid = dist_valid_q;
    assign dist_mm    = dist_mm_q;
    assign err_range  = err_range_q;
    assign err_noecho = err_noecho_q;
    assign overrun    = overrun_q;
    assign dist_avg   = sum_q[SumW-1:AVG_LOG2];
    assign avg_valid  = (fill_q == FillW'(Depth));

endmodule

// File: tb/tb_echo_range_calc.sv
// Bench for echo_range_calc: a default-scaled instance (a) and a unity-scale
// instance (b, MULT=1 SHIFT=0) checked against a queue-based reference model.
module tb_echo_range_calc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_rdy = 1'b0, a_flush = 1'b0, b_rdy = 1'b0, b_flush = 1'b0;
    logic [31:0] a_pw = '0, b_pw = '0;
    logic        a_busy, a_dv, a_er, a_en, a_ovr, a_av;
    logic        b_busy, b_dv, b_er, b_en, b_ovr, b_av;
    logic [15:0] a_mm, a_avg, b_mm, b_avg;

    int errors = 0;
    int checks = 0;
    int unsigned qa[$];
    int unsigned qb[$];

    echo_range_calc dut_a (
        .clk(clk), .rst(rst), .rdy(a_rdy), .pulse_width(a_pw), .flush(a_flush),
        .busy(a_busy), .dist_valid(a_dv), .dist_mm(a_mm), .err_range(a_er),
        .err_noecho(a_en), .overrun(a_ovr), .dist_avg(a_avg), .avg_valid(a_av)
    );

    echo_range_calc #(.MULT(1), .SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .rdy(b_rdy), .pulse_width(b_pw), .flush(b_flush),
        .busy(b_busy), .dist_valid(b_dv), .dist_mm(b_mm), .err_range(b_er),
        .err_noecho(b_en), .overrun(b_ovr), .dist_avg(b_avg), .avg_valid(b_av)
    );

    // Reference model: distance from plain arithmetic, average over the last 4 good samples.
    function automatic bit ref_is_err(input int unsigned pw);
        return (pw == 0) || (pw > 1200000);
    endfunction

    function automatic int unsigned ref_dist(input int sel, input int unsigned pw);
        longint unsigned p;
        p = longint'(pw) * ((sel != 0) ? 64'd1 : 64'd225);
        if (sel == 0) p = p / 65536;
        return (p > 65535) ? 65535 : int'(p);
    endfunction

    function automatic int unsigned ref_avg(input int sel);
        int unsigned s = 0;
        if (sel != 0) foreach (qb[i]) s += qb[i];
        else foreach (qa[i]) s += qa[i];
        return s / 4;
    endfunction

    function automatic bit ref_av(input int sel);
        return (sel != 0) ? (qb.size() == 4) : (qa.size() == 4);
    endfunction

    task automatic model_clear(input int sel);
        if (sel != 0) qb.delete(); else qa.delete();
    endtask

    task automatic model_push(input int sel, input int unsigned d);
        if (sel != 0) begin
            qb.push_back(d);
            if (qb.size() > 4) void'(qb.pop_front());
        end else begin
            qa.push_back(d);
            if (qa.size() > 4) void'(qa.pop_front());
        end
    endtask

    task automatic set_rdy(input int sel, input logic v);
        if (sel != 0) b_rdy = v; else a_rdy = v;
    endtask

    task automatic set_pw(input int sel, input logic [31:0] v);
        if (sel != 0) b_pw = v; else a_pw = v;
    endtask

    task automatic set_flush(input int sel, input logic v);
        if (sel != 0) b_flush = v; else a_flush = v;
    endtask

    task automatic get_out(input int sel, output logic busy, output logic dv,
                           output logic [15:0] mm, output logic er, output logic en,
                           output logic ovr, output logic [15:0] avg, output logic av);
        busy = (sel != 0) ? b_busy : a_busy;
        dv   = (sel != 0) ? b_dv   : a_dv;
        mm   = (sel != 0) ? b_mm   : a_mm;
        er   = (sel != 0) ? b_er   : a_er;
        en   = (sel != 0) ? b_en   : a_en;
        ovr  = (sel != 0) ? b_ovr  : a_ovr;
        avg  = (sel != 0) ? b_avg  : a_avg;
        av   = (sel != 0) ? b_av   : a_av;
    endtask

    // One measurement: optional rdy rise, optional flush at cycle flush_n,
    // optional second rise at cycle ovr_n; checks latency, result and average.
    task automatic do_sample(input int sel, input int unsigned pw, input bit raise,
                             input int flush_n, input int ovr_n);
        logic busy, dv, er, en, ovr, av;
        logic [15:0] mm, avg;
        int n, busy_cnt, ovr_cnt, extra_dv, exp_n;
        bit err;
        err   = ref_is_err(pw);
        exp_n = err ? 1 : 17;
        if (raise) begin
            @(negedge clk);
            set_pw(sel, pw);
            set_rdy(sel, 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        n = 0; busy_cnt = 0; ovr_cnt = 0;
        while (n < 40) begin
            get_out(sel, busy, dv, mm, er, en, ovr, avg, av);
            if (ovr) ovr_cnt++;
            if (dv) break;
            if (busy) busy_cnt++;
            set_flush(sel, n == flush_n);
            if (ovr_n >= 0 && n == ovr_n - 2) set_rdy(sel, 1'b0);
            if (ovr_n >= 0 && n == ovr_n) begin
                set_pw(sel, 10000);
                set_rdy(sel, 1'b1);
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        set_flush(sel, 1'b0);
        if (flush_n >= 0 && flush_n < exp_n) model_clear(sel);
        if (!err && flush_n != exp_n - 1) model_push(sel, ref_dist(sel, pw));

        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL latency pw=%0d: got %0d cycles, want %0d", pw, n, exp_n);
        end
        checks++;
        if (busy_cnt !== n || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy pw=%0d: high %0d cycles (end %b), want %0d (end 0)",
                     pw, busy_cnt, busy, n);
        end
        checks++;
        if (mm !== 16'((err) ? 65535 : ref_dist(sel, pw))) begin
            errors++;
            $display("FAIL dist_mm pw=%0d: got %0d, want %0d", pw, mm,
                     err ? 65535 : ref_dist(sel, pw));
        end
        checks++;
        if (er !== (pw > 1200000) || en !== (pw == 0)) begin
            errors++;
            $display("FAIL err_flags pw=%0d: got range=%b noecho=%b, want %b %b",
                     pw, er, en, pw > 1200000, pw == 0);
        end
        checks++;
        if (avg !== 16'(ref_avg(sel)) || av !== ref_av(sel)) begin
            errors++;
            $display("FAIL average pw=%0d: got avg=%0d valid=%b, want %0d %b",
                     pw, avg, av, ref_avg(sel), ref_av(sel));
        end
        checks++;
        if (ovr_cnt !== ((ovr_n >= 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL overrun pw=%0d: got %0d pulses, want %0d", pw, ovr_cnt,
                     (ovr_n >= 0) ? 1 : 0);
        end
        @(negedge clk);
        get_out(sel, busy, dv, mm, er, en, ovr, avg, av);
        checks++;
        if (dv !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width pw=%0d: dist_valid=%b, want 0", pw, dv);
        end
        set_rdy(sel, 1'b0);
        if (ovr_n >= 0) begin
            extra_dv = 0;
            repeat (20) begin
                @(negedge clk);
                get_out(sel, busy, dv, mm, er, en, ovr, avg, av);
                if (dv) extra_dv++;
            end
            checks++;
            if (extra_dv !== 0) begin
                errors++;
                $display("FAIL dropped_sample: got %0d extra strobes, want 0", extra_dv);
            end
        end
    endtask

    task automatic idle_flush(input int sel);
        logic busy, dv, er, en, ovr, av;
        logic [15:0] mm, avg;
        @(negedge clk);
        set_flush(sel, 1'b1);
        @(negedge clk);
        set_flush(sel, 1'b0);
        model_clear(sel);
        get_out(sel, busy, dv, mm, er, en, ovr, avg, av);
        checks++;
        if (avg !== 16'd0 || av !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush: got avg=%0d valid=%b, want 0 0", avg, av);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_rdy = 1'b1; a_pw = '0;
        b_rdy = 1'b0; b_pw = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_busy, a_dv, a_mm, a_er, a_en, a_ovr, a_avg, a_av} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b dv=%b mm=%0d avg=%0d av=%b, want all 0",
                     a_busy, a_dv, a_mm, a_avg, a_av);
        end
        rst = 1'b1;
        model_clear(0);
        model_clear(1);
        // rdy already high: the first edge after release is the capture edge.
        do_sample(0, 0, 1'b0, -1, -1);
    endtask

    task automatic test_conversion();
        do_sample(0, 291375, 1'b1, -1, -1);
        do_sample(0, 10000, 1'b1, -1, -1);
        do_sample(0, 1200001, 1'b1, -1, -1);
        do_sample(0, 1200000, 1'b1, -1, -1);
        do_sample(0, 1, 1'b1, -1, -1);
    endtask

    task automatic test_average();
        idle_flush(1);
        for (int i = 1; i <= 5; i++) do_sample(1, 100 * i, 1'b1, -1, -1);
        checks++;
        if (b_avg !== 16'd350) begin
            errors++;
            $display("FAIL wrap_average: got %0d, want 350", b_avg);
        end
    endtask

    task automatic test_overrun();
        do_sample(0, 291375, 1'b1, -1, 5);
    endtask

    task automatic test_flush();
        idle_flush(1);
        for (int i = 0; i < 3; i++) do_sample(1, 1000 + i, 1'b1, -1, -1);
        do_sample(1, 2000, 1'b1, 16, -1);
        for (int i = 0; i < 4; i++) do_sample(1, 3000 + 7 * i, 1'b1, -1, -1);
        // Flush mid-conversion: that sample becomes the first entry.
        do_sample(1, 4444, 1'b1, 5, -1);
    endtask

    task automatic test_random();
        int unsigned pw;
        for (int i = 0; i < 10; i++) begin
            pw = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 1300000);
            do_sample(0, pw, 1'b1, -1, -1);
            pw = $urandom_range(0, 7) == 0 ? 1200001 + $urandom_range(0, 999)
                                           : $urandom_range(1, 70000);
            do_sample(1, pw, 1'b1, -1, -1);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a_pw = 291375;
        a_rdy = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_dv, a_avg, a_av, b_avg, b_av} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b dv=%b avg=%0d av=%b, want all 0",
                     a_busy, a_dv, a_avg, a_av);
        end
        a_rdy = 1'b0;
        model_clear(0);
        model_clear(1);
        @(negedge clk);
        rst = 1'b1;
        do_sample(0, 291375, 1'b1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_average();
        test_overrun();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/echo_range_calc.md
Name: echo_range_calc

Overview:
- Downstream consumer of the echo pulse-width measurement stage.
- Takes the held `pulse_width` word and its level-type `rdy` flag and detects each new measurement on the rising edge of `rdy`.
- Converts the cycle count to millimetres with a sequential shift-add multiply, range-checks the result, and keeps a power-of-two moving average.
- Feeds the display/control logic with per-sample distance, averaged distance and error flags.

Parameters:
- PW_W, 32, width of `pulse_width` input.
- MULT_W, 16, width of scale multiplier; also the number of multiply iterations.
- MULT, 225, scale numerator (mm per cycle × 2^SHIFT; 225 gives 50 MHz, 343 m/s, round trip).
- SHIFT, 16, right shift applied to the product.
- DIST_W, 16, width of distance outputs.
- MAX_PW, 1200000, largest valid pulse width in cycles (~4 m).
- AVG_LOG2, 2, log2 of moving-average depth (depth 4).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- rdy, in, 1, level: high = `pulse_width` holds a completed measurement.
- pulse_width, in, PW_W, measured echo width in clk cycles.
- flush, in, 1, sync clear of average buffer.
- busy, out, 1, conversion in progress.
- dist_valid, out, 1, one-cycle strobe: dist_mm/err flags updated.
- dist_mm, out, DIST_W, latest distance.
- err_range, out, 1, with dist_valid: sample > MAX_PW.
- err_noecho, out, 1, with dist_valid: sample == 0.
- overrun, out, 1, one-cycle strobe: new measurement arrived while busy, dropped.
- dist_avg, out, DIST_W, moving average of last 2^AVG_LOG2 good samples.
- avg_valid, out, 1, high once buffer full; cleared by flush/reset.

Behaviour:
- Reset values: all outputs 0; buffer, running sum, fill count and rdy_d cleared; state IDLE.
- Edge detect: rdy_d registers rdy. Event = rdy & ~rdy_d. The rdy rise right after upstream reset (pulse_width=0) is a normal event and yields err_noecho.
- FSM states: IDLE, MUL, UPD.
- IDLE: on event at edge E0, latch pw = pulse_width and set busy. If pw == 0 or pw > MAX_PW, go straight to UPD with error marked; otherwise go to MUL.
- MUL: one multiplier bit per cycle, LSB first. acc += pw << i when MULT[i] == 1. Accumulator is PW_W+MULT_W bits; no overflow is possible. Takes exactly MULT_W cycles (edges E1..E16), then goes to UPD.
- UPD (one cycle):
  - d = acc >> SHIFT, saturated to 2^DIST_W-1 if wider.
  - Error sample: dist_mm = all ones; the corresponding err flag is set; buffer untouched.
  - Good sample: dist_mm = d; buffer[wr_ptr] replaced. sum = sum - old + d, sum width DIST_W+AVG_LOG2. wr_ptr wraps modulo depth. Fill count saturates at depth.
  - Registered at this edge: dist_valid = 1, busy = 0, return to IDLE.
- Latency: good sample dist_valid high in the cycle after edge E0+MULT_W+1 (E17 with defaults); error sample after E1.
- dist_avg = sum >> AVG_LOG2 (truncating). Updated in the same cycle as dist_valid. avg_valid rises with the dist_valid of the depth-th good sample.
- Event while busy: sample dropped, overrun strobes one cycle, conversion in flight unaffected.
- flush: clears buffer, sum, fill count, avg_valid and dist_avg next edge. A conversion in flight still completes and its good sample becomes the first buffer entry. If flush and UPD coincide, flush wins and the sample is discarded from the average only; dist_mm is still updated.
- rdy held high: no new event. rdy falling: no action.
- Async reset mid-conversion: aborts immediately, everything returns to reset values.

Decomposition:
- Shared package: FSM state encoding, default MULT/SHIFT/MAX_PW constants for the 50 MHz board.
- One sub-module is natural: `seq_shift_add_mult`.
  - Inputs: start, operand, constant.
  - Outputs: product, done after MULT_W cycles.
  - Reusable for other unit conversions.
- Moving average stays in the top.

Test Plan:
- Reset then release, upstream shows rdy=1 with pulse_width=0 -> one dist_valid with err_noecho=1, dist_mm=16'hFFFF, avg_valid=0.
- pulse_width=291375, rdy 0->1 -> dist_valid exactly 17 cycles after the capture edge, dist_mm=1000, busy high for those cycles.
- pulse_width=10000 -> dist_mm=34; pulse_width=1200001 -> err_range=1, dist_mm=16'hFFFF, dist_avg unchanged.
- MULT=1, SHIFT=0 override, samples 100,200,300,400 -> avg_valid rises on the 4th strobe with dist_avg=250; 5th sample 500 -> dist_avg=350 (wrap-around).
- Second rdy rise 5 cycles into a conversion -> overrun pulse once, first result correct, no second dist_valid.
- flush asserted on the UPD cycle after 3 good samples -> avg_valid=0, dist_avg=0; then 4 new samples are required to reassert avg_valid.
